rr_dispatcher: RTL and testbench

RR_DISPATCHER -- requirements
Module: rr_dispatcher

---
 rtl/rr_dispatcher_if.sv | 27 ++
 rtl/rr_dispatcher.sv | 134 +++++++++++++
 tb/tb_rr_dispatcher.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_dispatcher_if.sv
// rr_dispatcher_if -- handshake bundle between one upstream stream and
// three downstream channels.
//   in_vld / in_rdy / in_data    : upstream valid/ready stream, DW-bit payload
//   out_vld / out_rdy / out_data : three downstream channels; channel k uses
//                                  bit k and data slice [k*DW +: DW]
// master: the environment (drives the upstream beat, consumes downstream).
// slave : the dispatcher itself.
interface rr_dispatcher_if #(
  parameter int DW = 8
);
  logic            in_vld;
  logic            in_rdy;
  logic [DW-1:0]   in_data;
  logic [2:0]      out_vld;
  logic [2:0]      out_rdy;
  logic [3*DW-1:0] out_data;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/rr_dispatcher.sv
// rr_dispatcher -- round-robin fan-out of one valid/ready stream onto three
// single-entry output channels.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : dispatch enable; 0 blocks new input, channels still drain
//   bus      : rr_dispatcher_if slave (upstream stream + three channels)
//   last_ch  : index of the most recently loaded channel
//   disp_cnt : accepted-beat counter, wraps at 256
//
// Priority pointer states:
//   state | meaning
//   PRI_0 | priority order 0 > 1 > 2
//   PRI_1 | priority order 1 > 2 > 0
//   PRI_2 | priority order 2 > 0 > 1
module rr_dispatcher #(
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  rr_dispatcher_if.slave bus,
  output logic [1:0]  last_ch,
  output logic [7:0]  disp_cnt
);

  typedef enum logic [1:0] {
    PRI_0 = 2'd0,
    PRI_1 = 2'd1,
    PRI_2 = 2'd2
  } ptr_e;

  ptr_e          ptr_q;
  ptr_e          ptr_d;
  logic [2:0]    full_q;
  logic [DW-1:0] data_q [3];
  logic [2:0]    avail;
  logic [1:0]    sel;
  logic          accept;
  logic [2:0]    load;

  // A full channel whose consumer is ready this cycle can be reloaded on the
  // same edge it drains, so it counts as available.
  assign avail = ~full_q | bus.out_rdy;

  always_comb begin
    sel = 2'd0;
    case (ptr_q)
      PRI_1: begin
        if (avail[1])      sel = 2'd1;
        else if (avail[2]) sel = 2'd2;
        else               sel = 2'd0;
      end
      PRI_2: begin
        if (avail[2])      sel = 2'd2;
        else if (avail[0]) sel = 2'd0;
        else               sel = 2'd1;
      end
      default: begin
        if (avail[0])      sel = 2'd0;
        else if (avail[1]) sel = 2'd1;
        else               sel = 2'd2;
      end
    endcase
  end

  // rst is folded in so upstream never sees ready while the block is held
  // in reset (avail is all ones then because every channel is empty).
  assign bus.in_rdy = en & (|avail) & ~rst;
  assign accept     = bus.in_vld & bus.in_rdy;

  always_comb begin
    load = 3'b000;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      case (sel)
        2'd0:    ptr_d = PRI_1;
        2'd1:    ptr_d = PRI_2;
        default: ptr_d = PRI_0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PRI_0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Reload wins over drain, so a same-cycle drain+reload keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (load[k]) begin
          full_q[k] <= 1'b1;
          data_q[k] <= bus.in_data;
        end else if (bus.out_rdy[k]) begin
          full_q[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ch  <= 2'd0;
      disp_cnt <= 8'd0;
    end else if (accept) begin
      last_ch  <= sel;
      disp_cnt <= disp_cnt + 8'd1;
    end
  end

  assign bus.out_vld = full_q;

  // Data registers are never cleared on drain; consumers qualify with out_vld.
  for (genvar g = 0; g < 3; g++) begin : g_out
    assign bus.out_data[g*DW +: DW] = data_q[g];
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// tb_rr_dispatcher -- randomized and directed stimulus for rr_dispatcher
// with a queue-based reference model and a decoupled output monitor.
module tb_rr_dispatcher;

  localparam int DW = 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] last_ch;
  logic [7:0] disp_cnt;

  rr_dispatcher_if #(.DW(DW)) bus ();

  rr_dispatcher #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .last_ch  (last_ch),
    .disp_cnt (disp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue of expected beats per channel. A non-empty
  // queue means the channel holds a beat; the front is what it must present.
  logic [DW-1:0] exp_q [3][$];
  int            ptr_m;
  logic [1:0]    last_m;
  logic [7:0]    cnt_m;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] occ_m();
    logic [2:0] o;
    for (int k = 0; k < 3; k++) o[k] = (exp_q[k].size() != 0);
    return o;
  endfunction

  // One clock cycle of stimulus. Inputs change on the falling edge; the
  // model decides acceptance from its own occupancy and pointer.
  task automatic step(input logic e, input logic v, input logic [DW-1:0] d, input logic [2:0] r);
    bit   found;
    int   s;
    logic rdy_m;
    @(negedge clk);
    en          = e;
    bus.in_vld  = v;
    bus.in_data = d;
    bus.out_rdy = r;
    #1;
    chk("out_vld", 32'(bus.out_vld), 32'(occ_m()));
    chk("last_ch", 32'(last_ch), 32'(last_m));
    chk("disp_cnt", 32'(disp_cnt), 32'(cnt_m));
    found = 1'b0;
    s     = 0;
    for (int i = 0; i < 3; i++) begin
      int c;
      c = (ptr_m + i) % 3;
      if (!found && (exp_q[c].size() == 0 || r[c])) begin
        found = 1'b1;
        s     = c;
      end
    end
    rdy_m = e && found;
    chk("in_rdy", 32'(bus.in_rdy), 32'(rdy_m));
    if (v && rdy_m) begin
      exp_q[s].push_back(d);
      ptr_m  = (s + 1) % 3;
      last_m = 2'(s);
      cnt_m  = cnt_m + 8'd1;
    end
  endtask

  // Asserts rst between edges and checks the asynchronous effect at once.
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
    bus.in_vld  = 1'b0;
    bus.out_rdy = 3'b000;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    ptr_m  = 0;
    last_m = 2'd0;
    cnt_m  = 8'd0;
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  // Monitor: every handshake on a channel must deliver the oldest expected
  // beat for that channel.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
        if (bus.out_vld[k] && bus.out_rdy[k]) begin
          if (exp_q[k].size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, bus.out_data[k*DW +: DW]);
          end else begin
            chk($sformatf("data_ch%0d", k), 32'(bus.out_data[k*DW +: DW]), 32'(exp_q[k].pop_front()));
          end
        end
      end
    end
  end

  logic [7:0] cnt_save;

  initial begin
    n_pass      = 0;
    n_total     = 0;
    ptr_m       = 0;
    last_m      = 2'd0;
    cnt_m       = 8'd0;
    rst         = 1'b1;
    en          = 1'b1;
    bus.in_vld  = 1'b1;
    bus.in_data = 8'h5A;
    bus.out_rdy = 3'b000;
    #2;
    chk("init_out_vld", 32'(bus.out_vld), 32'd0);
    chk("init_in_rdy", 32'(bus.in_rdy), 32'd0);
    chk("init_disp_cnt", 32'(disp_cnt), 32'd0);
    bus.in_vld = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b0;

    // Rotation with all consumers ready.
    step(1'b1, 1'b1, 8'hA1, 3'b111);
    step(1'b1, 1'b1, 8'hB2, 3'b111);
    step(1'b1, 1'b1, 8'hC3, 3'b111);
    step(1'b1, 1'b1, 8'hD4, 3'b111);
    step(1'b1, 1'b0, 8'h00, 3'b111);
    chk("rot_disp_cnt", 32'(disp_cnt), 32'd4);
    chk("rot_last_ch", 32'(last_ch), 32'd0);

    // Skip-busy: build ch1 full with pointer at 1, then X must go to ch2.
    do_reset();
    step(1'b1, 1'b1, 8'h10, 3'b000);
    step(1'b1, 1'b1, 8'h11, 3'b000);
    step(1'b1, 1'b1, 8'h12, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b101);
    step(1'b1, 1'b1, 8'h13, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b001);
    step(1'b1, 1'b1, 8'h7E, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("skip_last_ch", 32'(last_ch), 32'd2);
    chk("skip_data_ch2", 32'(bus.out_data[2*DW +: DW]), 32'h7E);
    chk("skip_out_vld", 32'(bus.out_vld), 32'b110);
    step(1'b1, 1'b1, 8'h3C, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("skip_next_ch0", 32'(last_ch), 32'd0);

    // Full backpressure, then a single-cycle drain+reload on ch1.
    step(1'b1, 1'b1, 8'hEE, 3'b000);
    chk("bp_in_rdy_low", 32'(bus.in_rdy), 32'd0);
    step(1'b1, 1'b1, 8'hEF, 3'b000);
    step(1'b1, 1'b1, 8'h9D, 3'b010);
    chk("bp_in_rdy_high", 32'(bus.in_rdy), 32'd1);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("bp_full", 32'(bus.out_vld), 32'b111);
    chk("bp_data_ch1", 32'(bus.out_data[DW +: DW]), 32'h9D);
    chk("bp_last_ch", 32'(last_ch), 32'd1);

    // Enable gating: nothing accepted, held beats drain.
    cnt_save = cnt_m;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 3'b111);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("en_disp_cnt", 32'(disp_cnt), 32'(cnt_save));
    chk("en_drained", 32'(bus.out_vld), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom), 3'($urandom));
    end
    step(1'b1, 1'b0, 8'h00, 3'b111);

    // Counter wrap after exactly 256 accepts.
    do_reset();
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'($urandom), 3'b111);
    step(1'b1, 1'b0, 8'h00, 3'b111);
    chk("wrap_disp_cnt", 32'(disp_cnt), 32'd0);

    // Reset with two channels holding beats.
    step(1'b1, 1'b1, 8'h21, 3'b000);
    step(1'b1, 1'b1, 8'h22, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("mid_two_full", 32'($countones(bus.out_vld)), 32'd2);
    bus.in_vld = 1'b1;
    do_reset();
    step(1'b1, 1'b1, 8'h44, 3'b000);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    chk("mid_next_ch0", 32'(bus.out_vld), 32'b001);
    chk("mid_data_ch0", 32'(bus.out_data[0 +: DW]), 32'h44);
    chk("mid_disp_cnt", 32'(disp_cnt), 32'd1);

    step(1'b1, 1'b0, 8'h00, 3'b111);
    step(1'b1, 1'b0, 8'h00, 3'b000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
